// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32-subset datapath.
//   Each instruction walks IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB),
//   then retires back to FETCH (run=1) or IDLE (run=0).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   run                     permit to start / continue fetching
//   opcode, zero            instruction[6:0] from IR, ALU zero flag
//   imem_ready, dmem_ready  memory handshakes for FETCH / MEM
//   imem_req .. alu_src     datapath strobes / selects
//   alu_op                  ALUOp for the ALU control block
//   state                   current FSM state
//   busy, illegal, timeout  status; illegal/timeout are sticky
//   retired                 completed-instruction count (wraps)
module multicycle_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        busy,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] retired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   retired_q, retired_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;

  logic          is_r, is_i, is_ld, is_sd, is_beq, is_legal;
  logic          retire;
  logic          in_instr;
  logic [CW-1:0] cnt_inc;
  logic          wait_expired;

  assign is_r     = (opcode == 7'b0110011);
  assign is_i     = (opcode == 7'b0010011);
  assign is_ld    = (opcode == 7'b0000011);
  assign is_sd    = (opcode == 7'b0100011);
  assign is_beq   = (opcode == 7'b1100011);
  assign is_legal = is_r | is_i | is_ld | is_sd | is_beq;

  // The wait that makes the count reach TIMEOUT is the last one tolerated:
  // a ready in that cycle still completes, a not-ready halts.
  assign cnt_inc      = cnt_q + 1'b1;
  assign wait_expired = (cnt_inc == CW'(TIMEOUT));

  assign in_instr = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retired_d  = retired_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;

    // ALU controls depend only on the instruction class while it executes
    if (in_instr) begin
      alu_src = is_i | is_ld | is_sd;
      if (is_beq)           alu_op = 2'b01;
      else if (is_r | is_i) alu_op = 2'b10;
    end

    unique case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          pc_write = 1'b1;
          pc_src   = zero;
          retire   = 1'b1;
        end else if (is_ld | is_sd) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_read  = is_ld;
        mem_write = is_sd;
        if (dmem_ready) begin
          if (is_sd) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        pc_write   = 1'b1;
        retire     = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    if (retire) begin
      retired_d = retired_q + 32'd1;
      state_d   = run ? S_FETCH : S_IDLE;
    end

    // every state change starts a fresh wait window
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign state   = state_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign retired = retired_q;

endmodule
